shift_register_serializer: RTL and testbench



---
 rtl/shift_register_serializer.sv | 83 ++++++++
 tb/tb_shift_register_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_serializer.sv
// Wide-to-narrow unpacker: emits a loaded word MS chunk first, optionally only its top k chunks.
// Latency: first chunk valid the cycle after acceptance; back-to-back words with no bubble.
// Backpressure: outputs and state hold while m_valid && !m_ready; s_ready only when idle or on the last beat.
module shift_register_serializer #(
    parameter int DATA_INPUT_WIDTH  = 256,
    parameter int DATA_OUTPUT_WIDTH = 16,
    localparam int NUM_CHUNKS       = DATA_INPUT_WIDTH / DATA_OUTPUT_WIDTH,
    localparam int CNT_W            = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_INPUT_WIDTH-1:0]  s_data,
    input  logic [CNT_W-1:0]             s_chunks,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_OUTPUT_WIDTH-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         busy
);

    if (DATA_INPUT_WIDTH % DATA_OUTPUT_WIDTH != 0) begin : g_bad_width
        $error("DATA_INPUT_WIDTH must be an integer multiple of DATA_OUTPUT_WIDTH");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                      state_q, state_d;
    logic [DATA_INPUT_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]            rem_q, rem_d;
    logic [CNT_W-1:0]            eff_chunks;
    logic                        beat;
    logic                        accept;

    assign m_valid = (state_q == SHIFT);
    assign busy    = m_valid;
    assign m_data  = sr_q[DATA_INPUT_WIDTH-1 -: DATA_OUTPUT_WIDTH];
    assign m_last  = m_valid && (rem_q == CNT_W'(1));
    assign beat    = m_valid && m_ready;
    // Accepting on the last beat is what makes consecutive words gapless.
    assign s_ready = (state_q == IDLE) || (beat && m_last);
    assign accept  = s_valid && s_ready;

    always_comb begin
        eff_chunks = s_chunks;
        if ((s_chunks == '0) || (s_chunks > CNT_W'(NUM_CHUNKS))) begin
            eff_chunks = CNT_W'(NUM_CHUNKS);
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        if (beat) begin
            sr_d  = sr_q << DATA_OUTPUT_WIDTH;
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                state_d = IDLE;
            end
        end
        // A new word wins over the final shift of the previous one.
        if (accept) begin
            sr_d    = s_data;
            rem_d   = eff_chunks;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_shift_register_serializer.sv
// Bench for shift_register_serializer: queue-based chunk model checked every cycle,
// plus literal expectations on the captured output beats.
module tb_shift_register_serializer;
    localparam int IW = 256;
    localparam int OW = 16;
    localparam int NC = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] s_data = '0;
    logic [CW-1:0] s_chunks = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          busy;

    shift_register_serializer #(.DATA_INPUT_WIDTH(IW), .DATA_OUTPUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_chunks(s_chunks), .s_valid(s_valid),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    logic [OW-1:0] obs_d[$];
    logic          obs_l[$];
    int            obs_c[$];

    task automatic check(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_word(input logic [OW-1:0] base);
        logic [IW-1:0] w;
        w = '0;
        for (int i = 0; i < NC; i++) w[IW-1-OW*i -: OW] = base + OW'(i);
        return w;
    endfunction

    // Model: a word accepted now becomes its top eff chunks, queued in emission order.
    always @(negedge clk) begin
        bit ev;
        bit er;
        int eff;
        beat_t b;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            check("reset_m_valid", m_valid, 0);
        end else begin
            ev = exp_q.size() > 0;
            er = !ev || (m_ready && exp_q[0].l);
            check("m_valid", m_valid, ev);
            check("busy", busy, ev);
            check("s_ready", s_ready, er);
            if (ev) begin
                check("m_data", m_data, exp_q[0].d);
                check("m_last", m_last, exp_q[0].l);
            end
            if (m_valid && m_ready) begin
                obs_d.push_back(m_data);
                obs_l.push_back(m_last);
                obs_c.push_back(cyc);
            end
            if (ev && m_ready) void'(exp_q.pop_front());
            if (s_valid && er) begin
                eff = (s_chunks == 0 || int'(s_chunks) > NC) ? NC : int'(s_chunks);
                for (int i = 0; i < eff; i++) begin
                    b.d = s_data[IW-1-OW*i -: OW];
                    b.l = (i == eff - 1);
                    exp_q.push_back(b);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic clear_obs();
        obs_d.delete();
        obs_l.delete();
        obs_c.delete();
    endtask

    task automatic send(input logic [IW-1:0] d, input logic [CW-1:0] c);
        bit acc;
        acc = 1'b0;
        s_data   = d;
        s_chunks = c;
        s_valid  = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (exp_q.size() == 0) && !m_valid;
        end
        if (!done) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_seq16(input string nm, input logic [OW-1:0] base);
        check({nm, "_count"}, obs_d.size(), NC);
        for (int i = 0; i < NC && i < obs_d.size(); i++) begin
            check({nm, "_data"}, obs_d[i], base + OW'(i));
            check({nm, "_last"}, obs_l[i], (i == NC - 1));
        end
    endtask

    initial begin
        logic [IW-1:0] w;
        bit hit;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        clear_obs();
        send(mk_word(16'h0001), 0);
        drain();
        check_seq16("full", 16'h0001);

        clear_obs();
        w = {IW{1'b1}};
        w[IW-1 -: 3*OW] = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        send(w, 3);
        drain();
        check("part_count", obs_d.size(), 3);
        if (obs_d.size() == 3) begin
            check("part_b0", obs_d[0], 16'hAAAA);
            check("part_b1", obs_d[1], 16'hBBBB);
            check("part_b2", obs_d[2], 16'hCCCC);
            check("part_last", {obs_l[0], obs_l[1], obs_l[2]}, 3'b001);
        end
        check("part_idle_s_ready", s_ready, 1);

        clear_obs();
        rand_rdy = 1'b1;
        send(mk_word(16'h0001), 0);
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        check_seq16("stall", 16'h0001);

        clear_obs();
        send(mk_word(16'h1000), 0);
        send(mk_word(16'h2000), 0);
        drain();
        check("b2b_count", obs_d.size(), 32);
        if (obs_d.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                check("b2b_data", obs_d[i], (i < 16) ? 16'h1000 + 16'(i) : 16'h2000 + 16'(i - 16));
                check("b2b_last", obs_l[i], (i == 15 || i == 31));
            end
            check("b2b_gapless", obs_c[31] - obs_c[0], 31);
        end

        clear_obs();
        send(mk_word(16'h0001), 0);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = obs_d.size() >= 5;
            if (!hit) begin
                @(posedge clk);
                #1;
            end
        end
        if (!hit) check("rst_mid_timeout", 0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_valid", m_valid, 0);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_s_ready", s_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_residual", obs_d.size(), 5);
        clear_obs();
        send(mk_word(16'h0001), 0);
        drain();
        check_seq16("after_rst", 16'h0001);

        clear_obs();
        send(mk_word(16'h0001), 17);
        drain();
        check_seq16("oob17", 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
